// File: rtl/block_sum_pkg.sv
// Shared types and sizing helpers for the block sum reducer.
// Holds default parameters, width helpers and the result bundle.
package block_sum_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_BLOCK_LEN   = 8;
    localparam int DEF_INDEX_WIDTH = 16;

    // Total width: enough headroom that BLOCK_LEN max-value words never overflow.
    function automatic int sum_width(input int dw, input int bl);
        return dw + $clog2(bl + 1);
    endfunction

    // Counter width: must hold the value BLOCK_LEN itself.
    function automatic int cnt_width(input int bl);
        return $clog2(bl + 1);
    endfunction

    localparam int DEF_SUM_WIDTH = sum_width(DEF_DATA_WIDTH, DEF_BLOCK_LEN);
    localparam int DEF_CNT_WIDTH = cnt_width(DEF_BLOCK_LEN);

    typedef struct packed {
        logic [DEF_SUM_WIDTH-1:0]   sum;
        logic [DEF_CNT_WIDTH-1:0]   count;
        logic [DEF_INDEX_WIDTH-1:0] index;
    } result_t;

endpackage

// File: rtl/block_sum_reducer_if.sv
// Bus bundle for the reducer: show-ahead FIFO pop side and result side.
// master = reducer view (drives rdreq/result), slave = environment view.
interface block_sum_reducer_if
    import block_sum_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH   = DEF_SUM_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
);
    logic                   empty_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   rdreq_out;
    logic                   valid_out;
    logic [SUM_WIDTH-1:0]   sum_out;
    logic [CNT_WIDTH-1:0]   count_out;
    logic [INDEX_WIDTH-1:0] index_out;
    logic                   ready_in;

    modport master (
        input  empty_in, data_in, ready_in,
        output rdreq_out, valid_out, sum_out, count_out, index_out
    );

    modport slave (
        output empty_in, data_in, ready_in,
        input  rdreq_out, valid_out, sum_out, count_out, index_out
    );
endinterface

// File: rtl/block_sum_out_queue.sv
// 2-entry ready/valid FIFO of result bundles with full/empty flags.
// Ports: push/push_data in, full/empty flags, out_valid/out_data/out_ready.
module block_sum_out_queue
    import block_sum_pkg::*;
#(
    parameter type T = result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    output logic full,
    output logic empty,
    output logic out_valid,
    output T     out_data,
    input  logic out_ready
);
    T           mem [2];
    logic [1:0] q_count;
    logic       q_wr_ptr;
    logic       q_rd_ptr;
    logic       enq;
    logic       deq;

    assign deq = out_valid && out_ready;
    // A push while full is only accepted if a slot frees in the same cycle.
    assign enq = push && (!full || deq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            q_count  <= '0;
            q_wr_ptr <= 1'b0;
            q_rd_ptr <= 1'b0;
        end else begin
            if (enq) begin
                mem[q_wr_ptr] <= push_data;
                q_wr_ptr      <= !q_wr_ptr;
            end
            if (deq) begin
                q_rd_ptr <= !q_rd_ptr;
            end
            unique case ({enq, deq})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    assign full      = (q_count == 2'd2);
    assign empty     = (q_count == 2'd0);
    assign out_valid = !empty;
    assign out_data  = mem[q_rd_ptr];
endmodule

// File: rtl/block_sum_reducer.sv
// Pops a show-ahead FIFO and sums each BLOCK_LEN-word run into one total.
// Ports: clk, rst (async, active-low), flush_in, busy_out, bus (master).
module block_sum_reducer
    import block_sum_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BLOCK_LEN   = DEF_BLOCK_LEN,
    parameter int SUM_WIDTH   = sum_width(DATA_WIDTH, BLOCK_LEN),
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    localparam int CNT_WIDTH  = cnt_width(BLOCK_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_in,
    output logic                busy_out,
    block_sum_reducer_if.master bus
);
    typedef struct packed {
        logic [SUM_WIDTH-1:0]   sum;
        logic [CNT_WIDTH-1:0]   count;
        logic [INDEX_WIDTH-1:0] index;
    } res_t;

    logic [SUM_WIDTH-1:0]   acc;
    logic [SUM_WIDTH-1:0]   acc_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [INDEX_WIDTH-1:0] index;
    logic                   flush_pending;
    logic                   flush_req;
    logic                   pop;
    logic                   full_close;
    logic                   flush_close;
    logic                   close;
    logic                   pend_next;
    logic                   q_full;
    logic                   q_empty;
    res_t                   push_data;
    res_t                   out_data;

    // Gated by rst so nothing is requested while reset is held.
    // Stalls on a full queue even mid-block, so every close can enqueue.
    assign pop           = rst && !bus.empty_in && !q_full;
    assign bus.rdreq_out = pop;

    assign flush_req = flush_in || flush_pending;

    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (pop) begin
            acc_next = acc + SUM_WIDTH'(bus.data_in);
            cnt_next = cnt + CNT_WIDTH'(1);
        end
    end

    assign full_close  = pop && (cnt == CNT_WIDTH'(BLOCK_LEN - 1));
    // Empty blocks are never emitted: a flush needs a held or popped word.
    assign flush_close = flush_req && !q_full && ((cnt != '0) || pop);
    assign close       = full_close || flush_close;
    // A flush that cannot enqueue yet is remembered until space frees.
    assign pend_next   = flush_req && q_full && (cnt != '0);

    assign push_data = '{sum: acc_next, count: cnt_next, index: index};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc           <= '0;
            cnt           <= '0;
            index         <= '0;
            flush_pending <= 1'b0;
        end else begin
            flush_pending <= pend_next;
            if (close) begin
                acc   <= '0;
                cnt   <= '0;
                index <= index + INDEX_WIDTH'(1);
            end else begin
                acc <= acc_next;
                cnt <= cnt_next;
            end
        end
    end

    block_sum_out_queue #(
        .T(res_t)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (close),
        .push_data(push_data),
        .full     (q_full),
        .empty    (q_empty),
        .out_valid(bus.valid_out),
        .out_data (out_data),
        .out_ready(bus.ready_in)
    );

    assign bus.sum_out   = out_data.sum;
    assign bus.count_out = out_data.count;
    assign bus.index_out = out_data.index;

    assign busy_out = (cnt != '0) || !q_empty || flush_pending;
endmodule

// File: doc/block_sum_reducer.md
Name: block_sum_reducer

Overview:
Consumer stage placed directly downstream of the TimesFiveContained result FIFO read port. It pops the result stream through a show-ahead empty/rdreq interface and sums each run of BLOCK_LEN consecutive words into one wide total. Each total goes out on a ready/valid port, tagged with a block sequence index, through a 2-entry output queue. A flush input closes a partial block early.

Parameters:
DATA_WIDTH, 32, width of popped words
BLOCK_LEN, 8, words per block; legal range 1..65535
SUM_WIDTH, DATA_WIDTH+$clog2(BLOCK_LEN+1), total width; sized so a sum never overflows
INDEX_WIDTH, 16, width of the block sequence number

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
empty_in  in  1  upstream FIFO empty
data_in  in  DATA_WIDTH  upstream head word; valid while empty_in=0 (show-ahead)
rdreq_out  out  1  pop upstream head this cycle
flush_in  in  1  single-cycle pulse: close current partial block
valid_out  out  1  result available
sum_out  out  SUM_WIDTH  block total
count_out  out  $clog2(BLOCK_LEN+1)  words in this block (BLOCK_LEN, or fewer on flush)
index_out  out  INDEX_WIDTH  block sequence number
ready_in  in  1  downstream accepts result
busy_out  out  1  partial block held or output queue non-empty

Behaviour:
- Reset (rst=0, async): acc=0, cnt=0, index=0, queue empty. rdreq_out=0, valid_out=0, sum_out/count_out/index_out=0, busy_out=0.
- Pop rule (combinational): rdreq_out = !empty_in && !q_full. No pop while the queue holds 2 entries, including mid-block pops. The stall is deliberately conservative.
- On a pop: acc_next = acc + zero-extended data_in; cnt_next = cnt+1.
- Close condition: (pop && cnt==BLOCK_LEN-1) or (flush_in && (cnt>0 || pop)).
- On close: enqueue {acc_next, cnt_next, index}, then acc=0, cnt=0, index=index+1. index wraps from 2^INDEX_WIDTH-1 to 0.
- Flush in the same cycle as a pop includes the popped word.
- Flush with cnt==0 and no pop is ignored: no empty blocks, index unchanged.
- Flush coinciding with a full-block close produces a single result.
- Enqueue is always legal on close, because a pop was only possible with !q_full. A flush-only close needs !q_full. If the queue is full, flush_in is held pending in a 1-bit register until space frees.
- Latency: the closing pop in cycle t gives valid_out=1 in cycle t+1. A BLOCK_LEN=1 close therefore has 1-cycle latency.
- Output queue: 2-entry FIFO, registered outputs. Transfer occurs when valid_out && ready_in.
- valid_out, once high, holds with stable sum/count/index until transfer.
- Enqueue and dequeue in the same cycle when full: legal, occupancy stays 2. rdreq_out is still 0 that cycle because it uses the registered q_full.
- busy_out = (cnt!=0) || !q_empty || flush_pending.
- No internal FSM beyond the accumulator and queue pointers. State: acc, cnt, index, flush_pending, q_wr_ptr, q_rd_ptr, q_count.

Decomposition:
- Shared package block_sum_pkg holds:
  - typedef result_t {sum, count, index}
  - SUM_WIDTH helper function
  - default parameters
- One sub-module: block_sum_out_queue. It is a 2-entry ready/valid FIFO of result_t with full/empty flags and async active-low reset.
- Accumulate and close logic stays in block_sum_reducer.

Test Plan:
- Basic block: feed TimesFiveContained outputs 0,5,...,35 (8 words), ready_in=1 -> one result sum=140, count=8, index=0, one cycle after the 8th pop.
- Back-to-back blocks: feed 5*i for i=0..23, ready_in=1 -> sums 140, 460, 780 with index 0, 1, 2. rdreq_out stays high whenever empty_in=0.
- Backpressure: ready_in=0 for 60 cycles with 24 words available -> exactly 16 words popped, then rdreq_out=0 with 2 results held stable. On ready_in=1, the remaining 8 words are consumed and 3 results arrive in order.
- Flush:
  - 3 words {5,10,15} then flush_in -> sum=30, count=3.
  - A second flush with cnt=0 -> no result, index unchanged.
  - flush_in on the same cycle as the 4th pop -> count=4 with the word included.
- Width/wrap:
  - 8 words of 0xFFFFFFFF -> sum=0x7FFFFFFF8.
  - Preload index via 65536 BLOCK_LEN=1 blocks -> index wraps 65535 to 0.
- Reset mid-block: assert rst=0 after 5 pops, asynchronously mid-cycle -> valid_out, rdreq_out, busy_out drop immediately. After release, the next 8 words produce sum over those 8 only, with index=0.
